// File: rtl/admode1_operand_fetch.sv
// Addressing-mode-1 operand fetch: decodes shifter_operand, reads Rm/Rs through the
// single synchronous register-file port and presents a handshaked bundle to the shifter.
module admode1_operand_fetch #(
    parameter logic [31:0] PC_IMM_OFS = 32'd8,
    parameter logic [31:0] PC_REG_OFS = 32'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        in_c,
    output logic        rf_re,
    output logic [3:0]  rf_addr,
    input  logic [31:0] rf_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] base,
    output logic [7:0]  amount,
    output logic        rg,
    output logic        f_c,
    output logic [1:0]  typ
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RM   = 3'd1,
        S_RS   = 3'd2,
        S_FIN  = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_op;
    logic [31:0] r_pc;
    logic [31:0] r_base;
    logic [7:0]  r_amount;
    logic        r_rg;
    logic        r_fc;
    logic [1:0]  r_typ;

    logic [3:0]  w_rm;
    logic [3:0]  w_rs;
    logic        w_reg_shift;
    logic [31:0] w_rm_val;
    logic [31:0] w_rs_val;
    logic        w_unused_bits;

    assign w_rm          = r_op[3:0];
    assign w_rs          = r_op[11:8];
    assign w_reg_shift   = r_op[4];
    assign w_unused_bits = &{in_instr[31:26], in_instr[24:12]};

    // r15 reads are substituted by the latched PC plus the pipeline offset of the form
    assign w_rm_val = (w_rm == 4'd15) ? (r_pc + (w_reg_shift ? PC_REG_OFS : PC_IMM_OFS)) : rf_rdata;
    assign w_rs_val = (w_rs == 4'd15) ? (r_pc + PC_REG_OFS) : rf_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next = in_instr[25] ? S_OUT : S_RM;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RM:    w_next = w_reg_shift ? S_RS : S_FIN;
            S_RS:    w_next = S_FIN;
            S_FIN:   w_next = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_OUT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_OUT);
        rf_re     = 1'b0;
        rf_addr   = 4'd0;
        case (r_state)
            S_RM: begin
                rf_addr = w_rm;
                rf_re   = (w_rm != 4'd15);
            end
            S_RS: begin
                rf_addr = w_rs;
                rf_re   = (w_rs != 4'd15);
            end
            default: begin
                rf_re   = 1'b0;
                rf_addr = 4'd0;
            end
        endcase
    end

    // Instruction latch and shifter bundle registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= 12'd0;
            r_pc     <= 32'd0;
            r_base   <= 32'd0;
            r_amount <= 8'd0;
            r_rg     <= 1'b0;
            r_fc     <= 1'b0;
            r_typ    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op <= in_instr[11:0];
                        r_pc <= in_pc;
                        r_fc <= in_c;
                        if (in_instr[25]) begin
                            r_base <= {24'd0, in_instr[7:0]};
                            if (in_instr[11:8] == 4'd0) begin
                                r_typ    <= 2'b00;
                                r_amount <= 8'd0;
                                r_rg     <= 1'b0;
                            end else begin
                                r_typ    <= 2'b11;
                                r_amount <= {3'b000, in_instr[11:8], 1'b0};
                                r_rg     <= 1'b1;
                            end
                        end else begin
                            r_typ <= in_instr[6:5];
                            r_rg  <= in_instr[4];
                            if (!in_instr[4]) begin
                                r_amount <= {3'b000, in_instr[11:7]};
                            end
                        end
                    end
                end
                S_RS: r_base <= w_rm_val;
                S_FIN: begin
                    if (w_reg_shift) begin
                        r_amount <= w_rs_val[7:0];
                    end else begin
                        r_base <= w_rm_val;
                    end
                end
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign base   = r_base;
    assign amount = r_amount;
    assign rg     = r_rg;
    assign f_c    = r_fc;
    assign typ    = r_typ;

endmodule

// File: tb/tb_admode1_operand_fetch.sv
// Directed, table-driven bench for admode1_operand_fetch with a small register-file model.
module tb_admode1_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_c;
    logic        rf_re;
    logic [3:0]  rf_addr;
    logic [31:0] rf_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] base;
    logic [7:0]  amount;
    logic        rg;
    logic        f_c;
    logic [1:0]  typ;

    int checks = 0;
    int failures = 0;
    int n_reads = 0;
    logic [3:0] last_addr = 4'd0;
    logic [31:0] rf [16];

    admode1_operand_fetch dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_c(in_c),
        .rf_re(rf_re), .rf_addr(rf_addr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .base(base), .amount(amount), .rg(rg), .f_c(f_c), .typ(typ)
    );

    always #5 clk = ~clk;

    // Synchronous register-file model with a read counter
    always @(posedge clk) begin
        if (rf_re) begin
            rf_rdata  <= rf[rf_addr];
            n_reads   <= n_reads + 1;
            last_addr <= rf_addr;
        end
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        c;
        logic [31:0] e_base;
        logic [7:0]  e_amount;
        logic [1:0]  e_typ;
        logic        e_rg;
        int          e_lat;
        int          e_reads;
        logic [3:0]  e_addr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic c);
        in_instr = instr;
        in_pc    = pc;
        in_c     = c;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int lat;
        int r0;
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; in_c = 1'b0;
        out_ready = 1'b1; rf_rdata = 32'd0;
        for (int i = 0; i < 16; i++) rf[i] = 32'hA5A50000 + i;
        rf[1] = 32'hDEADBEEF; rf[2] = 32'h00000120; rf[3] = 32'h80000000;
        rf[4] = 32'h000001FF; rf[5] = 32'h00000007;

        //            instr          pc            c     base          amt    typ   rg    lat reads addr
        vecs[0] = '{32'h020004FF, 32'h00000000, 1'b0, 32'h000000FF, 8'd8,  2'b11, 1'b1, 1, 0, 4'd0};
        vecs[1] = '{32'h0200002A, 32'h00000040, 1'b1, 32'h0000002A, 8'd0,  2'b00, 1'b0, 1, 0, 4'd0};
        vecs[2] = '{32'h000002A3, 32'h00000100, 1'b0, 32'h80000000, 8'd5,  2'b01, 1'b0, 3, 1, 4'd3};
        vecs[3] = '{32'h0000021F, 32'h00001000, 1'b1, 32'h0000100C, 8'h20, 2'b00, 1'b1, 4, 1, 4'd2};
        vecs[4] = '{32'h0000000F, 32'hFFFFFFFC, 1'b0, 32'h00000004, 8'd0,  2'b00, 1'b0, 3, 0, 4'd0};
        vecs[5] = '{32'h00000F71, 32'h000012F8, 1'b1, 32'hDEADBEEF, 8'h04, 2'b11, 1'b1, 4, 1, 4'd1};
        vecs[6] = '{32'h00000453, 32'h00000000, 1'b0, 32'h80000000, 8'hFF, 2'b10, 1'b1, 4, 2, 4'd4};
        vecs[7] = '{32'h02000F01, 32'h00000000, 1'b1, 32'h00000001, 8'd30, 2'b11, 1'b1, 1, 0, 4'd0};
        vecs[8] = '{32'h00000045, 32'h00000000, 1'b0, 32'h00000007, 8'd0,  2'b10, 1'b0, 3, 1, 4'd5};

        // Reset state
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_rf_re", {31'd0, rf_re}, 32'd0);
        chk("rst_rf_addr", {28'd0, rf_addr}, 32'd0);
        chk("rst_bundle", {base ^ {amount, 24'd0}, 27'd0, rg, f_c, typ, 1'b0}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            chk($sformatf("v%0d_in_ready", v), {31'd0, in_ready}, 32'd1);
            r0 = n_reads;
            issue(vecs[v].instr, vecs[v].pc, vecs[v].c);
            lat = 1;
            while (!out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            chk($sformatf("v%0d_latency", v), lat, vecs[v].e_lat);
            chk($sformatf("v%0d_base", v), base, vecs[v].e_base);
            chk($sformatf("v%0d_amount", v), {24'd0, amount}, {24'd0, vecs[v].e_amount});
            chk($sformatf("v%0d_typ", v), {30'd0, typ}, {30'd0, vecs[v].e_typ});
            chk($sformatf("v%0d_rg", v), {31'd0, rg}, {31'd0, vecs[v].e_rg});
            chk($sformatf("v%0d_f_c", v), {31'd0, f_c}, {31'd0, vecs[v].c});
            chk($sformatf("v%0d_reads", v), n_reads - r0, vecs[v].e_reads);
            if (vecs[v].e_reads > 0) chk($sformatf("v%0d_last_addr", v), {28'd0, last_addr}, {28'd0, vecs[v].e_addr});
            @(posedge clk); #1;
            chk($sformatf("v%0d_drop_valid", v), {31'd0, out_valid}, 32'd0);
            chk($sformatf("v%0d_held_base", v), base, vecs[v].e_base);
        end

        // Reset while in RS discards the instruction
        issue(32'h00000213, 32'h00000000, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_rf_re", {31'd0, rf_re}, 32'd0);
        chk("midrst_base", base, 32'd0);
        chk("midrst_fields", {20'd0, amount, rg, f_c, typ}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_idle_after", {30'd0, in_ready, out_valid}, 32'd2);

        // Backpressure: bundle held, second offer ignored until the handshake
        out_ready = 1'b0;
        issue(32'h0200002A, 32'h00000000, 1'b1);
        in_instr = 32'h02000F01; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_state", k), {30'd0, out_valid, in_ready}, 32'd2);
            chk($sformatf("bp%0d_bundle", k), {base[23:0], amount}, 32'h00002A00);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_state", {30'd0, out_valid, in_ready}, 32'd1);
        chk("bp_release_base", base, 32'h0000002A);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_second_base", base, 32'h00000001);
        chk("bp_second_amount", {24'd0, amount}, 32'd30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/admode1_operand_fetch.md
Name: admode1_operand_fetch

Overview:
- Front end that feeds the addressing-mode-1 shifter. Decodes the shifter_operand field of an ARM data-processing instruction.
- Fetches Rm and, when needed, Rs through the single synchronous register-file read port.
- Presents a registered, handshaked {base, amount, rg, f_c, typ} bundle to the shifter, which computes the final operand and carry-out.

Parameters:
PC_IMM_OFS, 32'd8, value added to the latched PC when Rm/Rs = r15 and the shift amount is immediate
PC_REG_OFS, 32'd12, value added to the latched PC when Rm/Rs = r15 and the shift amount comes from Rs

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset: one clock, synchronous, active-high
in_valid  in  1  instruction offered
in_ready  out  1  block can accept; high only in IDLE
in_instr  in  32  instruction; only [25] and [11:0] are used
in_pc  in  32  address of the instruction
in_c  in  1  CPSR C flag
rf_re  out  1  register-file read enable
rf_addr  out  4  register-file read address
rf_rdata  in  32  read data, valid the cycle after rf_re
out_valid  out  1  shifter bundle valid
out_ready  in  1  downstream consumes bundle
base  out  32  shifter base value
amount  out  8  shift or rotate amount
rg  out  1  amount came from a register; also forced to 1 for a rotated immediate
f_c  out  1  latched C flag
typ  out  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR

Behaviour:
- Reset: state = IDLE, in_ready = 1. out_valid, rf_re, rf_addr, base, amount, rg, f_c and typ all = 0.
- Reset mid-operation discards the instruction in flight. No rf_re is asserted in the cycle after reset.
- Accept: in IDLE, when in_valid && in_ready (cycle T), latch in_instr, in_pc and in_c.
- States and transitions:
  - IDLE, I=1 (immediate) -> OUT.
  - IDLE, I=0, bit4=0 (immediate shift) -> RM -> FIN -> OUT.
  - IDLE, I=0, bit4=1 (register shift) -> RM -> RS -> FIN -> OUT.
- Latency, accept cycle to out_valid: immediate = 1 cycle, immediate shift = 3, register shift = 4.
- RM: rf_re = 1, rf_addr = instr[3:0].
- RS:
  - capture Rm from rf_rdata into base;
  - rf_re = 1, rf_addr = instr[11:8].
- FIN:
  - immediate shift: capture Rm into base.
  - register shift: capture rf_rdata[7:0] into amount.
- r15 handling: when the addressed register is 15, rf_re stays 0 in that cycle. The substituted value is latched_pc + PC_IMM_OFS for an immediate shift, latched_pc + PC_REG_OFS for a register shift. Arithmetic is 32-bit, wrapping modulo 2^32. For Rs = 15, amount = low byte of that sum. State timing is unchanged.
- Field mapping:
  - Immediate, rot = instr[11:8], imm8 = instr[7:0]:
    - base = zero-extended imm8.
    - rot = 0: typ = 00, amount = 0, rg = 0.
    - rot != 0: typ = 11, amount = {3'b0, rot, 1'b0}, rg = 1.
  - Immediate shift: typ = instr[6:5], amount = {3'b0, instr[11:7]}, rg = 0. Amount 0 is passed through unchanged, so the shifter decodes it as LSR #32, ASR #32 or RRX.
  - Register shift: typ = instr[6:5], rg = 1. Amount is the full Rs byte, unclamped; values 0 and >= 32 are left to the shifter.
- In all forms f_c = latched in_c.
- OUT:
  - out_valid = 1 and the bundle is held stable until out_ready.
  - out_valid && out_ready -> IDLE. in_ready rises the next cycle, so there is no same-cycle re-accept.
- in_valid outside IDLE is ignored.
- The bundle registers keep their last values after the handshake. Only out_valid drops.

Test Plan:
- Reset mid-fetch: assert rst while in RS for one cycle -> next cycle state IDLE, all outputs 0, in_ready = 1; no rf_re in the cycle after reset.
- Immediate rotate: in_instr = 0x020004FF (I=1, rot=4, imm=0xFF) -> cycle T+1: base = 0x000000FF, typ = 11, amount = 8, rg = 1, no rf_re.
- Immediate, no rotate: in_instr[25]=1, [11:0] = 0x02A, in_c = 1 -> base = 0x2A, typ = 00, amount = 0, rg = 0, f_c = 1, out_valid at T+1.
- Immediate-shift LSR: [11:0] = 0x2A3, rf[3] = 0x80000000 -> rf_re with addr 3 at T+1; out at T+3 with base = 0x80000000, amount = 5, typ = 01, rg = 0.
- Register shift with PC: [11:0] = 0x21F, in_pc = 0x00001000, rf[2] = 0x00000120 -> one rf_re (addr 2, at T+2); out at T+4 with base = 0x0000100C, amount = 0x20, typ = 00, rg = 1.
- Backpressure: hold out_ready = 0 for 5 cycles -> bundle stable, in_ready = 0, a second in_valid is ignored; out_ready = 1 -> IDLE next cycle, second instruction then accepted.
